muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
//  - Sits beside the EX-stage ALU and is selected by the R-type Funct field.
//  - Executes MULT/MULTU/DIV/DIVU over multiple cycles, one bit per cycle.
//  - Executes MTHI/MTLO in a single cycle.
//  - Exposes a busy/done handshake that the hazard unit uses to stall MFHI/MFLO and any new mul/div.
// PARAMETERS
//  WIDTH   32  operand width; the product is 2*WIDTH bits wide; HI and LO are WIDTH bits each
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1       core clock, rising edge
//  rst       in   1       asynchronous reset, active-high
//  start     in   1       issue strobe from EX, qualified by funct
//  funct     in   6       R-type Funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//  rs_val    in   WIDTH   operand A (dividend / multiplicand / MTHI-MTLO source)
//  rt_val    in   WIDTH   operand B (divisor / multiplier)
//  flush     in   1       pipeline flush; aborts an in-flight operation
//  busy      out  1       an operation is in flight; HI and LO are not yet valid
//  done      out  1       one-cycle pulse; HI and LO hold the new result in this cycle
//  hi        out  WIDTH   HI register
//  lo        out  WIDTH   LO register
//  div_zero  out  1       present only when MULDIV_DIVZERO_EN is defined
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; div_zero=0.
//  States:
//   - IDLE: start with a mul/div funct -> CALC.
//   - CALC: runs WIDTH iterations -> FIX.
//   - FIX: -> IDLE.
//  Start acceptance:
//   - start is sampled only in IDLE; start while busy=1 is ignored (the hazard unit must stall).
//   - start with any other funct is ignored.
//  MTHI/MTLO:
//   - In IDLE, hi<=rs_val or lo<=rs_val at that edge.
//   - No busy, no done, and the other register is untouched.
//  Mul/div accept edge E0:
//   - Latch operands. Signed ops take |A| and |B| and record the result signs.
//   - busy<=1 and counter<=0.
//  CALC iteration step (one per clock):
//   - Multiply: shift-add.
//   - Divide: restoring shift-subtract.
//   - After WIDTH iterations (edge E0+WIDTH) -> FIX.
//  FIX, edge E0+WIDTH+1:
//   - Apply sign correction.
//   - Write hi and lo; done<=1 for exactly one cycle; busy<=0.
//  Latency: busy is high for WIDTH+1 cycles; results are visible in the cycle done=1.
//  Result mapping:
//   - MULT/MULTU: {hi,lo} = the 2*WIDTH-bit product, two's complement for MULT.
//   - DIV/DIVU: lo = quotient, hi = remainder.
//   - Signed quotient: truncated toward zero.
//   - Signed remainder: takes the sign of the dividend.
//  Overflow case, DIV of MIN_INT by -1:
//   - lo = MIN_INT (wraps), hi = 0.
//   - No exception.
//  Divide by zero: the result follows the restoring algorithm.
//   - DIVU: lo = all ones, hi = rs_val.
//   - DIV: sign correction is applied to those magnitudes.
//  flush:
//   - In CALC or FIX: return to IDLE at the next edge; busy<=0; no done; hi/lo unchanged.
//   - flush with start in the same cycle: flush wins and the start is dropped.
//  hi/lo hold their value at every edge except an MTHI/MTLO write or a FIX edge.
// CONFIGURATION
//  MULDIV_DIVZERO_EN, defined:
//   - DIV/DIVU with rt_val=0 skips CALC.
//   - FIX occurs at E0+1, so busy lasts 1 cycle.
//   - Results: lo = all ones, hi = rs_val.
//   - div_zero=1 in the done cycle; otherwise div_zero=0.
//  MULDIV_DIVZERO_EN, undefined:
//   - No div_zero port.
//   - Divide by zero runs the full WIDTH+1 cycles with the algorithmic result described above.
// TESTING
//  1. MULT rs=0xFFFFFFFD(-3), rt=7 -> done at E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
//  2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3. DIV rs=-7(0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU rs=0x1234, rt=0:
//     - macro on: done at E0+1, lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
//     - macro off: done at E0+33, same hi/lo.
//  5. MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on back-to-back cycles -> hi=0xA5A5A5A5, lo=0x5A5A5A5A; busy stays 0.
//  6. MULT issued; flush at E0+10; a second start at E0+5 -> busy=0 at E0+11; no done; hi/lo keep their old values; the E0+5 start is ignored.
//     Assert rst at E0+20 of a DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the mul/div unit.
// Optional div_zero flag exists only when MULDIV_DIVZERO_EN is defined.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
  logic             div_zero;
`endif

  modport master (
    output start, funct, rs_val, rt_val, flush,
`ifdef MULDIV_DIVZERO_EN
    input  busy, done, hi, lo, div_zero
`else
    input  busy, done, hi, lo
`endif
  );

  modport slave (
    input  start, funct, rs_val, rt_val, flush,
`ifdef MULDIV_DIVZERO_EN
    output busy, done, hi, lo, div_zero
`else
    output busy, done, hi, lo
`endif
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO, one bit per cycle.
// MULDIV_DIVZERO_EN: short-circuit divide by zero and flag it.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_q, dz_d;
  logic             div_zero_q, div_zero_d;
`endif

  logic is_mul, is_div, is_sgn;
  logic is_mthi, is_mtlo;
  assign is_mul  = (bus.funct == F_MULT)
                || (bus.funct == F_MULTU);
  assign is_div  = (bus.funct == F_DIV)
                || (bus.funct == F_DIVU);
  assign is_sgn  = (bus.funct == F_MULT)
                || (bus.funct == F_DIV);
  assign is_mthi = (bus.funct == F_MTHI);
  assign is_mtlo = (bus.funct == F_MTLO);

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = is_sgn & bus.rs_val[WIDTH-1];
  assign b_neg = is_sgn & bus.rt_val[WIDTH-1];
  assign a_mag = a_neg ? -bus.rs_val : bus.rs_val;
  assign b_mag = b_neg ? -bus.rt_val : bus.rt_val;

  // acc holds {partial, multiplier} or {remainder, quotient}
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q}
                              : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_q[W2-1:WIDTH],
                     acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0]
                             : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[W2-1:WIDTH]
                             : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_mul_d = is_mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULDIV_DIVZERO_EN
    dz_d       = dz_q;
    div_zero_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          unique case (1'b1)
            is_mthi: hi_d = bus.rs_val;
            is_mtlo: lo_d = bus.rs_val;
            is_mul: begin
              state_d  = CALC;
              cnt_d    = '0;
              busy_d   = 1'b1;
              is_mul_d = 1'b1;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opnd_d   = a_mag;
`ifdef MULDIV_DIVZERO_EN
              dz_d     = 1'b0;
`endif
            end
            is_div: begin
              state_d  = CALC;
              cnt_d    = '0;
              busy_d   = 1'b1;
              is_mul_d = 1'b0;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opnd_d   = b_mag;
`ifdef MULDIV_DIVZERO_EN
              dz_d     = 1'b0;
              // Preload the final answer and go straight to FIX
              if (bus.rt_val == '0) begin
                state_d  = FIX;
                dz_d     = 1'b1;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                acc_d    = {bus.rs_val, {WIDTH{1'b1}}};
              end
`endif
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_mul_q)
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else if (div_diff[WIDTH])
            acc_d = {div_sh[WIDTH-1:0],
                     acc_q[WIDTH-2:0], 1'b0};
          else
            acc_d = {div_diff[WIDTH-1:0],
                     acc_q[WIDTH-2:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1))
            state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_mul_q) begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
`ifdef MULDIV_DIVZERO_EN
          div_zero_d = dz_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_DIVZERO_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_mul_q <= is_mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign bus.div_zero = div_zero_q;
`endif
endmodule
